// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// - bp_ctr_t        : 2-bit saturating branch-direction counter encoding
// - DEFAULT_RESET_PC: default program counter value loaded on reset
// - ctr_inc/ctr_dec : saturating counter helpers
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,  // strongly not taken
        BP_WNT = 2'b01,  // weakly not taken
        BP_WT  = 2'b10,  // weakly taken
        BP_ST  = 2'b11   // strongly taken
    } bp_ctr_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
        return (c == BP_ST) ? BP_ST : bp_ctr_t'(c + 2'd1);
    endfunction

    function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
        return (c == BP_SNT) ? BP_SNT : bp_ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit counter per entry.
// Lookup port (combinational, sees registered contents only):
//   lookup_pc            in  PC to look up
//   lookup_hit           out entry valid and tag matches
//   lookup_predict_taken out direction bit (counter MSB) of the indexed entry
//   lookup_target        out stored target of the indexed entry
// Update port (written at the rising edge, visible the following cycle):
//   update_valid, update_pc, update_target, update_taken
module branch_target_buffer
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic            lookup_predict_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];
    bp_ctr_t          ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[XLEN-1:IDX_W+2];

    assign lookup_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lookup_predict_taken = ctr_q[lk_idx][1];
    assign lookup_target        = target_q[lk_idx];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_WNT;
            end
        end else if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    ctr_q[up_idx]    <= ctr_inc(ctr_q[up_idx]);
                    target_q[up_idx] <= update_target;
                end else begin
                    ctr_q[up_idx] <= ctr_dec(ctr_q[up_idx]);
                end
            end else if (update_taken) begin
                // Allocation evicts whatever occupied this index.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= BP_WT;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and BTB prediction.
// Inputs : clk, reset (sync, active-high), stall, flush + redirect_pc,
//          branch resolution (update_valid/pc/target/taken), imem_rdata
// Outputs: imem_addr (= PC), IF_pc, IF_pc_plus_4, IF_instruction,
//          IF_branch_estimation
// Next-PC priority: reset > flush > stall > predicted target > pc + 4.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned     BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_pc,
    output logic [XLEN-1:0] IF_pc_plus_4,
    output logic [31:0]     IF_instruction,
    output logic            IF_branch_estimation
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus_4;
    logic            btb_hit;
    logic            btb_dir;
    logic [XLEN-1:0] btb_target;
    logic            predict_taken;

    // Redirect targets are forced word-aligned.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    branch_target_buffer #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk                  (clk),
        .reset                (reset),
        .lookup_pc            (pc_q),
        .lookup_hit           (btb_hit),
        .lookup_predict_taken (btb_dir),
        .lookup_target        (btb_target),
        .update_valid         (update_valid),
        .update_pc            (update_pc),
        .update_target        (update_target),
        .update_taken         (update_taken)
    );

    assign pc_plus_4     = pc_q + XLEN'(4);
    assign predict_taken = btb_hit & btb_dir;

    always_comb begin
        pc_next = pc_plus_4;
        if (flush) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (stall) begin
            pc_next = pc_q;
        end else if (predict_taken) begin
            pc_next = btb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign imem_addr            = pc_q;
    assign IF_pc                = pc_q;
    assign IF_pc_plus_4         = pc_plus_4;
    assign IF_instruction       = imem_rdata;
    assign IF_branch_estimation = predict_taken;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed, table-driven bench for instruction_fetch_stage.
// Each table row holds the inputs driven for one cycle and the PC/prediction
// expected to be visible at the start of that cycle.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_pc;
    logic [31:0] IF_pc_plus_4;
    logic [31:0] IF_instruction;
    logic        IF_branch_estimation;

    localparam logic [31:0] IMEM_XOR = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    // Simple instruction memory: word is a fixed function of the address.
    assign imem_rdata = imem_addr ^ IMEM_XOR;

    instruction_fetch_stage #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .flush                (flush),
        .redirect_pc          (redirect_pc),
        .update_valid         (update_valid),
        .update_pc            (update_pc),
        .update_target        (update_target),
        .update_taken         (update_taken),
        .imem_addr            (imem_addr),
        .imem_rdata           (imem_rdata),
        .IF_pc                (IF_pc),
        .IF_pc_plus_4         (IF_pc_plus_4),
        .IF_instruction       (IF_instruction),
        .IF_branch_estimation (IF_branch_estimation)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [31:0] redir;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic [31:0] exp_pc;
        logic        exp_est;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input logic [31:0] epc, input logic eest);
        check("IF_pc", row, IF_pc, epc);
        check("imem_addr", row, imem_addr, epc);
        check("IF_pc_plus_4", row, IF_pc_plus_4, epc + 32'd4);
        check("IF_instruction", row, IF_instruction, epc ^ IMEM_XOR);
        check("IF_branch_estimation", row, {31'd0, IF_branch_estimation}, {31'd0, eest});
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl,
                         input logic [31:0] redir, input logic uv,
                         input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utk);
        reset         = rst;
        stall         = stl;
        flush         = fl;
        redirect_pc   = redir;
        update_valid  = uv;
        update_pc     = upc;
        update_target = utgt;
        update_taken  = utk;
    endtask

    // row helper: rst, stall, flush, redirect, uv, upc, utgt, utaken, exp_pc, exp_est
    task automatic add(input logic rst, input logic stl, input logic fl,
                       input logic [31:0] redir, input logic uv,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input logic utk, input logic [31:0] epc, input logic eest);
        vecs.push_back('{rst, stl, fl, redir, uv, upc, utgt, utk, epc, eest});
    endtask

    initial begin
        // Sequential fetch from reset
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0000, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0004, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0008, 0);
        // Allocate 0x20 -> 0x100 taken
        add(0,0,0,32'h0,  1,32'h20, 32'h100,1, 32'h0000_000C, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0010, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0014, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0018, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_001C, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0020, 1);
        // Two not-taken updates: 10 -> 01 -> 00
        add(0,0,0,32'h0,  1,32'h20, 32'h0,  0, 32'h0000_0100, 0);
        add(0,0,0,32'h0,  1,32'h20, 32'h0,  0, 32'h0000_0104, 0);
        add(0,0,1,32'h20, 0,32'h0,  32'h0,  0, 32'h0000_0108, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0020, 0);
        // Alias: allocate 0x420 (index 8) evicting 0x20
        add(0,0,0,32'h0,  1,32'h420,32'h300,1, 32'h0000_0024, 0);
        add(0,0,1,32'h20, 0,32'h0,  32'h0,  0, 32'h0000_0028, 0);
        add(0,0,1,32'h420,0,32'h0,  32'h0,  0, 32'h0000_0020, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0420, 1);
        // Read-before-write: lookup at 0x420 while demoting it
        add(0,0,1,32'h420,0,32'h0,  32'h0,  0, 32'h0000_0300, 0);
        add(0,0,0,32'h0,  1,32'h420,32'h0,  0, 32'h0000_0420, 1);
        add(0,0,1,32'h420,0,32'h0,  32'h0,  0, 32'h0000_0300, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0420, 0);
        // Stall / flush interaction at 0x40
        add(0,0,1,32'h40, 0,32'h0,  32'h0,  0, 32'h0000_0424, 0);
        add(0,1,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0040, 0);
        add(0,1,1,32'h203,0,32'h0,  32'h0,  0, 32'h0000_0040, 0);
        add(0,1,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0200, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0200, 0);
        // Wrap-around
        add(0,0,1,32'hFFFF_FFFC,0,32'h0,32'h0,0, 32'h0000_0204, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'hFFFF_FFFC, 0);
        // Reset with flush and update: reset wins, BTB cleared, no write
        add(1,0,1,32'h500,1,32'h0,  32'h80, 1, 32'h0000_0000, 0);
        add(0,0,1,32'h420,0,32'h0,  32'h0,  0, 32'h0000_0000, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0420, 0);
        add(0,0,0,32'h0,  0,32'h0,  32'h0,  0, 32'h0000_0424, 0);

        drive(1,0,0,32'h0,0,32'h0,32'h0,0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(0,0,0,32'h0,0,32'h0,32'h0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            check_outputs(i, vecs[i].exp_pc, vecs[i].exp_est);
            drive(vecs[i].rst, vecs[i].stl, vecs[i].fl, vecs[i].redir,
                  vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].utk);
            @(negedge clk);
        end

        // Hand sequence: stall on a predicted-taken PC holds PC and prediction,
        // then release follows the stored target. Also checks counter
        // saturation: two taken hits push 10 -> 11, then two not-taken
        // updates leave 01, still a hit but predicted not taken.
        drive(0,0,1,32'h60,1,32'h60,32'h90,1);
        @(negedge clk);
        drive(0,1,0,32'h0,0,32'h0,32'h0,0);
        check_outputs(100, 32'h60, 1);
        @(negedge clk);
        check_outputs(101, 32'h60, 1);
        drive(0,1,0,32'h0,1,32'h60,32'h90,1);
        @(negedge clk);
        check_outputs(102, 32'h60, 1);
        drive(0,0,0,32'h0,1,32'h60,32'h94,1);
        @(negedge clk);
        // target overwritten to 0x94 by the last taken hit is not yet used here
        check_outputs(103, 32'h90, 0);
        drive(0,0,1,32'h60,1,32'h60,32'h0,0);
        @(negedge clk);
        drive(0,0,0,32'h0,1,32'h60,32'h0,0);
        check_outputs(104, 32'h60, 1);   // 11 -> 10 at this edge, still taken
        @(negedge clk);
        // counter now 01: lookup at 0x94 target; redirect back to 0x60
        check_outputs(105, 32'h94, 0);
        drive(0,0,1,32'h60,0,32'h0,32'h0,0);
        @(negedge clk);
        drive(0,0,0,32'h0,0,32'h0,32'h0,0);
        check_outputs(106, 32'h60, 0);
        @(negedge clk);
        check_outputs(107, 32'h64, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
